flipper_swing_sequencer: RTL and testbench
==========================================

// Module: flipper_swing_sequencer
// PURPOSE
//   Frame-paced state machine that sequences one flipper through its swing: rest, rise, hold, fall.
//   It converts the flip key into a saturating angle index that selects the flipper sprite.
//   It also emits a kick speed used by ball collision logic while the flipper is rising.
//   One instance per flipper; it sits between the key decoder and the flipper drawing/collision logic.
// PARAMETERS
//   ANGLE_W        4    width of angle output
//   ANGLE_MAX      15   fully raised angle index (<= 2**ANGLE_W-1)
//   UP_STEP        4    angle increment per frame while rising
//   DOWN_STEP      2    angle decrement per frame while falling
//   HOLD_MAX       120  max frames in HOLD before forced release (anti-stuck)
//   KICK_SPEED     400  signed speed magnitude sent to ball while rising
// PORTS
//   clk            in   1        system clock
//   reset          in   1        asynchronous, active-high reset
//   startOfFrame   in   1        one-clk pulse per video frame; all updates gated by it
//   keyFlip        in   1        flip key level (1 = pressed)
//   enable         in   1        game active; 0 forces flipper down
//   angle          out  ANGLE_W  current flipper angle index, 0 = rest
//   swingUp        out  1        1 while state == RISE
//   kickSpeed      out  11 s     KICK_SPEED when swingUp, else 0
//   flipCount      out  8        number of RISE entries, wraps 255->0
// BEHAVIOUR
// - Reset (async, immediate): state=REST, angle=0, armed=1, holdCnt=0, flipCount=0; swingUp=0, kickSpeed=0.
// - All registers change only on clk edges with startOfFrame=1; otherwise they hold. Latency: 1 clk after SOF.
// - armed: set at any SOF with keyFlip=0; cleared on entry to RISE (key must be released between flips).
// - REST: angle=0. If keyFlip & armed & enable -> RISE, angle=min(UP_STEP,ANGLE_MAX), flipCount+1.
// - RISE: if !keyFlip or !enable -> FALL, angle unchanged. Else angle=min(angle+UP_STEP,ANGLE_MAX);
//   if the new angle == ANGLE_MAX -> HOLD, holdCnt=0.
// - HOLD: angle=ANGLE_MAX, holdCnt+1 per SOF. If !keyFlip, !enable, or holdCnt reaches HOLD_MAX-1 -> FALL.
// - FALL: angle=max(angle-DOWN_STEP,0); if the new angle==0 -> REST.
//   If keyFlip & armed & enable -> RISE instead (re-flip), angle=min(angle+UP_STEP,ANGLE_MAX), flipCount+1.
// - Arithmetic uses ANGLE_W+1-bit intermediates; saturate at both ends, never wrap.
// - SOF priority: enable=0 beats key; re-flip beats the FALL decrement; the armed update uses the same SOF's key.
// - swingUp/kickSpeed are decoded combinationally from state; kickSpeed is a positive signed value.
// TESTING (ANGLE_MAX=15, UP_STEP=4, DOWN_STEP=2, HOLD_MAX=8, KICK_SPEED=400)
// 1 Key held, SOF x4 -> angle 4,8,12,15, state HOLD after the 4th SOF. swingUp=1/kickSpeed=400 after
//   SOFs 1-3 and 0 after SOF 4. flipCount=1.
// 2 Key stays held in HOLD -> FALL after 8 SOFs. angle 13,11,...,1,0 -> REST. No re-rise while held (armed=0).
// 3 Release at angle 8 during RISE -> FALL at the next SOF with angle 8. Then 6,4,2,0 -> REST.
// 4 Release, then press while falling at angle 9 -> RISE 13, then 15 -> HOLD. flipCount increments.
// 5 Toggle keyFlip with startOfFrame=0 -> no register change. Assert reset mid-RISE ->
//   angle=0 and state=REST with no clock edge.
// 6 enable=0 in HOLD -> FALL at the next SOF. A press in REST with enable=0 is ignored.
//   255 flips -> flipCount wraps to 0.

Source files
------------

// File: rtl/flipper_swing_sequencer.sv
// Frame-paced flipper swing sequencer: rest -> rise -> hold -> fall.
// Produces a saturating sprite angle index, a kick speed while rising and a flip counter.
module flipper_swing_sequencer #(
  parameter int unsigned ANGLE_W    = 4,
  parameter int unsigned ANGLE_MAX  = 15,
  parameter int unsigned UP_STEP    = 4,
  parameter int unsigned DOWN_STEP  = 2,
  parameter int unsigned HOLD_MAX   = 120,
  parameter int unsigned KICK_SPEED = 400
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      startOfFrame,
  input  logic                      keyFlip,
  input  logic                      enable,
  output logic [ANGLE_W-1:0]        angle,
  output logic                      swingUp,
  output logic signed [10:0]        kickSpeed,
  output logic [7:0]                flipCount
);

  localparam int unsigned EXT_W  = ANGLE_W + 1;
  localparam int unsigned HOLD_W = $clog2(HOLD_MAX + 1);

  localparam logic [EXT_W-1:0]   MAX_EXT   = EXT_W'(ANGLE_MAX);
  localparam logic [EXT_W-1:0]   UP_EXT    = EXT_W'(UP_STEP);
  localparam logic [EXT_W-1:0]   DOWN_EXT  = EXT_W'(DOWN_STEP);
  localparam logic [ANGLE_W-1:0] ANGLE_TOP = ANGLE_W'(ANGLE_MAX);
  localparam logic [HOLD_W-1:0]  HOLD_LAST = HOLD_W'(HOLD_MAX - 1);

  typedef enum logic [1:0] {
    REST = 2'd0,
    RISE = 2'd1,
    HOLD = 2'd2,
    FALL = 2'd3
  } swingState;

  swingState         state;
  logic              armed;
  logic [HOLD_W-1:0] holdCnt;

  logic [EXT_W-1:0]   angleExt;
  logic [EXT_W-1:0]   riseSum;
  logic [ANGLE_W-1:0] angleUp;
  logic [ANGLE_W-1:0] angleDown;
  logic               flipStart;

  // One-bit-wider intermediates so both saturations are detected without wrap.
  assign angleExt  = {1'b0, angle};
  assign riseSum   = angleExt + UP_EXT;
  assign angleUp   = (riseSum >= MAX_EXT) ? ANGLE_TOP : riseSum[ANGLE_W-1:0];
  assign angleDown = (angleExt <= DOWN_EXT) ? '0 : ANGLE_W'(angleExt - DOWN_EXT);
  assign flipStart = keyFlip & armed & enable;

  assign swingUp   = (state == RISE);
  assign kickSpeed = swingUp ? 11'(KICK_SPEED) : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= REST;
      angle     <= '0;
      armed     <= 1'b1;
      holdCnt   <= '0;
      flipCount <= '0;
    end else if (startOfFrame) begin
      // Releasing the key between frames re-arms the next flip.
      if (!keyFlip) armed <= 1'b1;
      case (state)
        REST: begin
          angle <= '0;
          if (flipStart) begin
            state     <= RISE;
            angle     <= angleUp;
            armed     <= 1'b0;
            flipCount <= flipCount + 8'd1;
          end
        end
        RISE: begin
          if (!keyFlip || !enable) begin
            state <= FALL;
          end else begin
            angle <= angleUp;
            if (angleUp == ANGLE_TOP) begin
              state   <= HOLD;
              holdCnt <= '0;
            end
          end
        end
        HOLD: begin
          angle   <= ANGLE_TOP;
          holdCnt <= holdCnt + HOLD_W'(1);
          if (!keyFlip || !enable || holdCnt == HOLD_LAST) state <= FALL;
        end
        FALL: begin
          // A fresh press mid-fall re-flips from the current angle.
          if (flipStart) begin
            state     <= RISE;
            angle     <= angleUp;
            armed     <= 1'b0;
            flipCount <= flipCount + 8'd1;
          end else begin
            angle <= angleDown;
            if (angleDown == '0) state <= REST;
          end
        end
        default: state <= REST;
      endcase
    end
  end

endmodule

// File: tb/tb_flipper_swing_sequencer.sv
// Bench for flipper_swing_sequencer: directed scenarios with literal expectations,
// then randomized frames, all compared every cycle against an integer behavioural model.
module tb_flipper_swing_sequencer;

  localparam int AMAX = 15;
  localparam int UP   = 4;
  localparam int DN   = 2;
  localparam int HMAX = 8;
  localparam int KICK = 400;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              startOfFrame = 1'b0;
  logic              keyFlip = 1'b0;
  logic              enable = 1'b1;
  logic [3:0]        angle;
  logic              swingUp;
  logic signed [10:0] kickSpeed;
  logic [7:0]        flipCount;

  flipper_swing_sequencer #(
    .ANGLE_W(4), .ANGLE_MAX(15), .UP_STEP(4), .DOWN_STEP(2),
    .HOLD_MAX(8), .KICK_SPEED(400)
  ) dut (
    .clk(clk), .reset(reset), .startOfFrame(startOfFrame), .keyFlip(keyFlip),
    .enable(enable), .angle(angle), .swingUp(swingUp), .kickSpeed(kickSpeed),
    .flipCount(flipCount)
  );

  always #5 clk = ~clk;

  int passCnt = 0;
  int totalCnt = 0;
  bit checkOn = 1'b0;

  // Model: phase 0 rest, 1 rising, 2 held up, 3 falling.
  int mPhase, mAngle, mFlips, mHeld;
  bit mArmed;

  function automatic void chk(string name, int act, int exp);
    totalCnt++;
    if (act == exp) passCnt++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endfunction

  function automatic void modelReset();
    mPhase = 0; mAngle = 0; mFlips = 0; mHeld = 0; mArmed = 1'b1;
  endfunction

  function automatic void modelFrame(bit key, bit en);
    bit fire;
    int raised;
    fire   = key && mArmed && en;
    raised = (mAngle + UP > AMAX) ? AMAX : mAngle + UP;
    if (!key) mArmed = 1'b1;
    if (fire && (mPhase == 0 || mPhase == 3)) begin
      mPhase = 1;
      mAngle = raised;
      mArmed = 1'b0;
      mFlips = (mFlips + 1) % 256;
    end else begin
      case (mPhase)
        1: if (!key || !en) mPhase = 3;
           else begin
             mAngle = raised;
             if (mAngle == AMAX) begin mPhase = 2; mHeld = 0; end
           end
        2: begin
             mHeld++;
             if (!key || !en || mHeld == HMAX) mPhase = 3;
           end
        3: begin
             mAngle = (mAngle - DN < 0) ? 0 : mAngle - DN;
             if (mAngle == 0) mPhase = 0;
           end
        default: mAngle = 0;
      endcase
    end
  endfunction

  always @(negedge clk) begin
    if (checkOn) begin
      chk("angle", int'(angle), mAngle);
      chk("swingUp", int'(swingUp), (mPhase == 1) ? 1 : 0);
      chk("kickSpeed", int'(kickSpeed), (mPhase == 1) ? KICK : 0);
      chk("flipCount", int'(flipCount), mFlips);
    end
  end

  // Apply inputs for one clock, advance the model on the edge, return 1ns after it.
  task automatic cyc(input bit sof, input bit key, input bit en);
    startOfFrame = sof; keyFlip = key; enable = en;
    @(posedge clk);
    if (reset) modelReset();
    else if (sof) modelFrame(key, en);
    #1;
  endtask

  task automatic litAngle(string name, int exp);
    chk(name, int'(angle), exp);
  endtask

  initial begin
    int expA[4];
    int expS[4];
    int falls[7];
    int startFlips;
    modelReset();
    checkOn = 1'b1;
    cyc(0, 0, 1);
    cyc(0, 0, 1);
    chk("reset angle", int'(angle), 0);
    chk("reset swingUp", int'(swingUp), 0);
    chk("reset kick", int'(kickSpeed), 0);
    chk("reset flipCount", int'(flipCount), 0);
    reset = 1'b0;
    cyc(0, 0, 1);

    // Key held: rise in steps of 4, saturating into hold.
    expA = '{4, 8, 12, 15};
    expS = '{1, 1, 1, 0};
    for (int i = 0; i < 4; i++) begin
      cyc(1, 1, 1);
      litAngle("rise angle", expA[i]);
      chk("rise swingUp", int'(swingUp), expS[i]);
      chk("rise kick", int'(kickSpeed), expS[i] * KICK);
    end
    chk("rise flipCount", int'(flipCount), 1);
    chk("model pins rise", mAngle, 15);

    // Held key: forced release after 8 hold frames, then fall to rest with no re-rise.
    for (int i = 0; i < 8; i++) cyc(1, 1, 1);
    litAngle("hold 8th frame angle", 15);
    cyc(1, 1, 1);
    litAngle("first fall angle", 13);
    falls = '{11, 9, 7, 5, 3, 1, 0};
    for (int i = 0; i < 7; i++) begin
      cyc(1, 1, 1);
      litAngle("forced fall angle", falls[i]);
    end
    cyc(1, 1, 1);
    litAngle("no re-rise held", 0);
    chk("no re-rise flipCount", int'(flipCount), 1);

    // Release mid-rise at angle 8.
    cyc(1, 0, 1);
    cyc(1, 1, 1);
    cyc(1, 1, 1);
    litAngle("rise to 8", 8);
    cyc(1, 0, 1);
    litAngle("release keeps 8", 8);
    chk("release swingUp", int'(swingUp), 0);
    for (int i = 0; i < 4; i++) cyc(1, 0, 1);
    litAngle("fall to rest", 0);
    chk("model pins rest", mPhase, 0);

    // Re-flip while falling at angle 9.
    for (int i = 0; i < 4; i++) cyc(1, 1, 1);
    chk("second hold flips", int'(flipCount), 3);
    for (int i = 0; i < 4; i++) cyc(1, 0, 1);
    litAngle("falling at 9", 9);
    cyc(1, 1, 1);
    litAngle("re-flip angle", 13);
    chk("re-flip swingUp", int'(swingUp), 1);
    chk("re-flip flipCount", int'(flipCount), 4);
    cyc(1, 1, 1);
    litAngle("re-flip hold angle", 15);
    chk("re-flip hold swingUp", int'(swingUp), 0);

    // Key toggles without frame pulses change nothing.
    cyc(0, 0, 1); cyc(0, 1, 1); cyc(0, 0, 1); cyc(0, 0, 0);
    litAngle("no-sof angle", 15);
    chk("no-sof flipCount", int'(flipCount), 4);
    for (int i = 0; i < 9; i++) cyc(1, 0, 1);
    litAngle("back to rest", 0);
    cyc(1, 1, 1);
    litAngle("rise before reset", 4);
    #2 reset = 1'b1;
    #1;
    modelReset();
    litAngle("async reset angle", 0);
    chk("async reset swingUp", int'(swingUp), 0);
    chk("async reset flipCount", int'(flipCount), 0);
    cyc(1, 1, 1);
    reset = 1'b0;

    // enable=0 forces hold into fall; presses ignored while disabled.
    for (int i = 0; i < 4; i++) cyc(1, 1, 1);
    litAngle("enable hold", 15);
    cyc(1, 1, 0);
    litAngle("disable fall start", 15);
    cyc(1, 1, 0);
    litAngle("disable falling", 13);
    for (int i = 0; i < 7; i++) cyc(1, 1, 0);
    cyc(1, 0, 0);
    cyc(1, 1, 0);
    litAngle("disabled press angle", 0);
    chk("disabled press swingUp", int'(swingUp), 0);
    chk("disabled press flipCount", int'(flipCount), 1);

    // Flip counter wraps 255 -> 0.
    cyc(1, 0, 1);
    startFlips = int'(flipCount);
    for (int i = 0; i < 256 - startFlips; i++) begin
      cyc(1, 1, 1);
      if (i == 254 - startFlips) chk("flipCount at 255", int'(flipCount), 255);
      cyc(1, 0, 1);
    end
    chk("flipCount wrap", int'(flipCount), 0);

    // Randomized frames, keys, enables and occasional resets.
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 199) == 0);
      if (reset) modelReset();
      cyc($urandom_range(0, 2) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 7) != 0);
    end
    reset = 1'b0;
    cyc(0, 0, 1);
    checkOn = 1'b0;

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
